mem_io_ctrl: RTL and testbench

//  Memory/IO controller behind the cpu's byte bus (mem_a/mem_dout/mem_wr/mem_din, rdy_in).
//  - Decodes 0x00000-0x1FFFF to the 128KB RAM, and 0x30000/0x30004 to the UART stream,
//    the cycle counter and program stop.
//  - Buffers rx and tx bytes in FIFOs and drops cpu_rdy while an IO access cannot complete.

---
 rtl/mem_io_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_io_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl
//   Memory/IO controller behind the cpu byte bus. Address decode (addr = cpu_a[17:0]):
//     0x00000-0x1FFFF  128KB RAM (ram_a = cpu_a[16:0], 1-cycle read latency on ram_din)
//     0x30000          UART stream: read pops rx FIFO, write pushes a non-zero byte to tx
//     0x30004          read: counter[7:0] and snapshot <= counter; write: push 0x00 + stop
//     0x30005-0x30007  snapshot bytes 1..3
//     anything else    unmapped: writes ignored, reads return 0x00
//   cpu_rdy drops while a read of 0x30000 finds rx empty, or while a tx-pushing write
//   finds tx full. Reads return on cpu_din two cycles after acceptance.
//
// Ports
//   clk_in, rst_in                  clock, asynchronous active-high reset
//   cpu_a/cpu_dout/cpu_wr           cpu request (held stable while cpu_rdy = 0)
//   cpu_din, cpu_rdy                registered read data, combinational accept
//   ram_a/ram_dout/ram_we/ram_din   external RAM
//   rx_valid/rx_data/rx_ready       incoming UART bytes into the rx FIFO
//   tx_valid/tx_data/tx_ready       outgoing UART bytes from the tx FIFO
//   stop, bad_addr                  sticky program-stop and illegal-address flags
//
// Build option
//   MEMIO_BOUNDS_CHECK_EN  when defined, an accepted unmapped access sets bad_addr
//                          (sticky) the following cycle; otherwise bad_addr is tied 0.

module mem_io_ctrl #(
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int TX_DEPTH_LOG2 = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        cpu_rdy,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_we,
    input  logic [7:0]  ram_din,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        stop,
    output logic        bad_addr
);

    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam logic [17:0] ADDR_UART = 18'h30000;
    localparam logic [17:0] ADDR_CNT  = 18'h30004;
    localparam logic [RX_DEPTH_LOG2:0] RX_PTR_ONE = 1;
    localparam logic [TX_DEPTH_LOG2:0] TX_PTR_ONE = 1;
    localparam logic [31:0] CNT_ONE = 32'd1;

    logic [17:0] addr_p0;
    logic        unused_cpu_a_hi;
    logic        sel_ram_p0, sel_uart_p0, sel_cnt_p0, sel_stop_p0;
    logic        tx_req_p0, acc_p0, vld_p0;
    logic [7:0]  tx_byte_p0, io_byte_p0;
    logic        stall_rx, stall_tx;

    logic [7:0]  rx_mem [RX_DEPTH];
    logic [RX_DEPTH_LOG2:0] rx_wr_ptr, rx_rd_ptr;
    logic        rx_empty, rx_full, rx_push, rx_pop;

    logic [7:0]  tx_mem [TX_DEPTH];
    logic [TX_DEPTH_LOG2:0] tx_wr_ptr, tx_rd_ptr;
    logic        tx_empty, tx_full, tx_push, tx_pop;

    logic [31:0] cycle_cnt, snapshot;

    logic        vld_p1, sel_ram_p1;
    logic [7:0]  io_byte_p1;

    // ---- p0: decode, FIFO status and acceptance ----
    assign addr_p0         = cpu_a[17:0];
    assign unused_cpu_a_hi = ^cpu_a[31:18];
    assign sel_ram_p0      = ~addr_p0[17];
    assign sel_uart_p0     = (addr_p0 == ADDR_UART);
    assign sel_cnt_p0      = (addr_p0[17:2] == ADDR_CNT[17:2]);
    assign sel_stop_p0     = (addr_p0 == ADDR_CNT);

    // Full when the wrap bits differ and the index bits match.
    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[RX_DEPTH_LOG2] != rx_rd_ptr[RX_DEPTH_LOG2]) &&
                      (rx_wr_ptr[RX_DEPTH_LOG2-1:0] == rx_rd_ptr[RX_DEPTH_LOG2-1:0]);
    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[TX_DEPTH_LOG2] != tx_rd_ptr[TX_DEPTH_LOG2]) &&
                      (tx_wr_ptr[TX_DEPTH_LOG2-1:0] == tx_rd_ptr[TX_DEPTH_LOG2-1:0]);

    // Writes that need a tx slot: non-zero byte to 0x30000, or any byte to 0x30004.
    assign tx_req_p0  = cpu_wr && ((sel_uart_p0 && (cpu_dout != 8'h00)) || sel_stop_p0);
    assign tx_byte_p0 = sel_uart_p0 ? cpu_dout : 8'h00;

    assign stall_rx = !cpu_wr && sel_uart_p0 && rx_empty;
    assign stall_tx = tx_req_p0 && tx_full;
    assign cpu_rdy  = !(stall_rx || stall_tx);
    assign acc_p0   = cpu_rdy && !rst_in;
    assign vld_p0   = acc_p0 && !cpu_wr;

    // RAM side; held at zero while reset is asserted.
    assign ram_we   = acc_p0 && cpu_wr && sel_ram_p0;
    assign ram_a    = rst_in ? 17'h0 : addr_p0[16:0];
    assign ram_dout = rst_in ? 8'h00 : cpu_dout;

    assign rx_ready = !rx_full && !rst_in;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = vld_p0 && sel_uart_p0;

    assign tx_push  = acc_p0 && tx_req_p0;
    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_data  = tx_valid ? tx_mem[tx_rd_ptr[TX_DEPTH_LOG2-1:0]] : 8'h00;

    // IO read byte; unmapped and RAM reads leave it at zero.
    always_comb begin
        io_byte_p0 = 8'h00;
        if (sel_uart_p0) begin
            io_byte_p0 = rx_mem[rx_rd_ptr[RX_DEPTH_LOG2-1:0]];
        end else if (sel_cnt_p0) begin
            case (addr_p0[1:0])
                2'd0:    io_byte_p0 = cycle_cnt[7:0];
                2'd1:    io_byte_p0 = snapshot[15:8];
                2'd2:    io_byte_p0 = snapshot[23:16];
                default: io_byte_p0 = snapshot[31:24];
            endcase
        end
    end

    // ---- p1/p2: control state, read pipeline valid, cpu_din load ----
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            cycle_cnt <= '0;
            snapshot  <= '0;
            stop      <= 1'b0;
            vld_p1    <= 1'b0;
            cpu_din   <= 8'h00;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
            if (vld_p0 && sel_stop_p0) snapshot <= cycle_cnt;
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_PTR_ONE;
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PTR_ONE;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PTR_ONE;
            if (tx_push && sel_stop_p0) stop <= 1'b1;
            vld_p1 <= vld_p0;
            if (vld_p1) cpu_din <= sel_ram_p1 ? ram_din : io_byte_p1;
        end
    end

    // ---- p1: datapath registers and FIFO storage ----
    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem[rx_wr_ptr[RX_DEPTH_LOG2-1:0]] <= rx_data;
        if (tx_push) tx_mem[tx_wr_ptr[TX_DEPTH_LOG2-1:0]] <= tx_byte_p0;
        sel_ram_p1 <= sel_ram_p0;
        io_byte_p1 <= io_byte_p0;
    end

`ifdef MEMIO_BOUNDS_CHECK_EN
    logic unmapped_p0;
    assign unmapped_p0 = !(sel_ram_p0 || sel_uart_p0 || sel_cnt_p0);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bad_addr <= 1'b0;
        end else if (acc_p0 && unmapped_p0) begin
            bad_addr <= 1'b1;
        end
    end
`else
    assign bad_addr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_io_ctrl.sv
`timescale 1ns/1ps
module tb_mem_io_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        stop;
    logic        bad_addr;

    mem_io_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
        .cpu_din(cpu_din), .cpu_rdy(cpu_rdy),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_we(ram_we), .ram_din(ram_din),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .stop(stop), .bad_addr(bad_addr)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_io  = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // External RAM: synchronous write, registered read.
    bit [7:0] ram_env [131072];
    always @(posedge clk_in) begin
        if (ram_we) ram_env[ram_a] <= ram_dout;
        ram_din <= ram_env[ram_a];
    end

    // Reference model: byte queues for the FIFOs, a plain memory, a cycle count
    // and a list of read results with the cycle they become visible.
    typedef struct { int due; logic [7:0] val; } rd_t;
    rd_t         pend [$];
    logic [7:0]  rxq [$];
    logic [7:0]  txq [$];
    bit   [7:0]  ram_m [131072];
    logic [31:0] cnt_m, snap_m;
    logic        stop_m, bad_m;
    logic [7:0]  din_m;
    int          cyc = 0;

    always @(negedge clk_in) begin
        logic [17:0] a;
        logic        exp_rdy, bad_hit;
        logic [7:0]  v;
        int          rx_pre;
        rd_t         e;
        cyc++;
        if (rst_in) begin
            rxq.delete(); txq.delete(); pend.delete();
            cnt_m = 0; snap_m = 0; stop_m = 0; bad_m = 0; din_m = 0;
        end else begin
            while (pend.size() > 0 && pend[0].due <= cyc) begin
                din_m = pend[0].val;
                void'(pend.pop_front());
            end
        end
        a = cpu_a[17:0];
        exp_rdy = !((!cpu_wr && a == 18'h30000 && rxq.size() == 0) ||
                    (cpu_wr && txq.size() == 16 &&
                     ((a == 18'h30000 && cpu_dout != 8'h00) || a == 18'h30004)));
        chk("cpu_rdy", cpu_rdy, exp_rdy);
        chk("ram_we", ram_we, !rst_in && exp_rdy && cpu_wr && !a[17]);
        chk("ram_a", ram_a, rst_in ? 17'h0 : cpu_a[16:0]);
        chk("ram_dout", ram_dout, rst_in ? 8'h00 : cpu_dout);
        chk("rx_ready", rx_ready, !rst_in && rxq.size() < 16);
        chk("tx_valid", tx_valid, txq.size() > 0);
        chk("tx_data", tx_data, (txq.size() > 0) ? txq[0] : 8'h00);
        chk("stop", stop, stop_m);
        chk("bad_addr", bad_addr, bad_m);
        chk("cpu_din", cpu_din, din_m);
        if (!rst_in) begin
            rx_pre  = rxq.size();
            bad_hit = 0;
            if (tx_ready && txq.size() > 0) void'(txq.pop_front());
            if (exp_rdy) begin
                if (cpu_wr) begin
                    if (!a[17]) ram_m[a[16:0]] = cpu_dout;
                    else if (a == 18'h30000 && cpu_dout != 8'h00) txq.push_back(cpu_dout);
                    else if (a == 18'h30004) begin txq.push_back(8'h00); stop_m = 1; end
                    else if (a != 18'h30000 && (a < 18'h30004 || a > 18'h30007)) bad_hit = 1;
                end else begin
                    v = 8'h00;
                    if (!a[17]) v = ram_m[a[16:0]];
                    else if (a == 18'h30000) v = rxq.pop_front();
                    else if (a == 18'h30004) begin v = cnt_m[7:0]; snap_m = cnt_m; end
                    else if (a == 18'h30005) v = snap_m[15:8];
                    else if (a == 18'h30006) v = snap_m[23:16];
                    else if (a == 18'h30007) v = snap_m[31:24];
                    else bad_hit = 1;
                    e.due = cyc + 2; e.val = v;
                    pend.push_back(e);
                end
            end
            if (rx_valid && rx_pre < 16) rxq.push_back(rx_data);
`ifdef MEMIO_BOUNDS_CHECK_EN
            if (bad_hit) bad_m = 1;
`endif
            cnt_m = cnt_m + 1;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (rand_io) begin
            rx_valid = ($urandom_range(0, 9) < 4);
            rx_data  = 8'($urandom);
            tx_ready = ($urandom_range(0, 1) == 1);
        end
    endtask

    task automatic set_cpu(input logic [31:0] a, input logic w, input logic [7:0] d);
        cpu_a = a; cpu_wr = w; cpu_dout = d;
    endtask

    task automatic set_idle();
        set_cpu(32'h0, 1'b0, 8'h00);
    endtask

    task automatic access(input logic [31:0] a, input logic w, input logic [7:0] d);
        bit done;
        int n;
        set_cpu(a, w, d);
        done = 0;
        n = 0;
        while (!done) begin
            @(negedge clk_in);
            done = cpu_rdy;
            tick();
            n++;
            if (!done && n >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL access_timeout: addr %0h still stalled after %0d cycles", a, n);
                done = 1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b0, b1, b2, b3;
        logic [31:0] r, a;
        rst_in = 1; rx_valid = 0; rx_data = 0; tx_ready = 0;
        set_idle();
        repeat (3) tick();
        @(negedge clk_in);
        chk("reset_din", cpu_din, 8'h00);
        chk("reset_stop", stop, 1'b0);
        chk("reset_txv", tx_valid, 1'b0);
        tick();
        rst_in = 0;

        // Counter snapshot 100 cycles out of reset.
        repeat (100) tick();
        set_cpu(32'h30004, 0, 0); tick();
        set_cpu(32'h30005, 0, 0); tick();
        set_cpu(32'h30006, 0, 0); @(negedge clk_in); b0 = cpu_din; tick();
        set_cpu(32'h30007, 0, 0); @(negedge clk_in); b1 = cpu_din; tick();
        set_idle();               @(negedge clk_in); b2 = cpu_din; tick();
        @(negedge clk_in); b3 = cpu_din;
        chk("t4_byte0", b0, 8'h64);
        chk("t4_snapshot", {b3, b2, b1, b0}, 32'd100);

        // RAM write then read, data two cycles after acceptance.
        tick();
        set_cpu(32'h10, 1, 8'hA5); tick();
        set_cpu(32'h10, 0, 8'h00); tick();
        set_idle(); tick();
        @(negedge clk_in);
        chk("t1_din", cpu_din, 8'hA5);
        chk("t1_rdy", cpu_rdy, 1'b1);

        // rx-empty stall released by an incoming byte.
        tick();
        set_cpu(32'h30000, 0, 0);
        @(negedge clk_in); chk("t2_stall", cpu_rdy, 1'b0);
        tick(); rx_valid = 1; rx_data = 8'h41;
        @(negedge clk_in); chk("t2_stall2", cpu_rdy, 1'b0);
        tick(); rx_valid = 0;
        @(negedge clk_in); chk("t2_accept", cpu_rdy, 1'b1);
        tick(); set_idle(); tick();
        @(negedge clk_in); chk("t2_din", cpu_din, 8'h41);
        tick(); set_cpu(32'h30000, 0, 0);
        @(negedge clk_in); chk("t2_empty", cpu_rdy, 1'b0);
        tick(); set_idle();

        // tx full stall, release by one pop, zero byte ignored, then drain.
        for (int i = 1; i <= 16; i++) access(32'h30000, 1, 8'(i));
        set_cpu(32'h30000, 1, 8'h77);
        @(negedge clk_in); chk("t3_full", cpu_rdy, 1'b0);
        tick();
        @(negedge clk_in); chk("t3_full2", cpu_rdy, 1'b0);
        tick(); tx_ready = 1;
        @(negedge clk_in); chk("t3_full3", cpu_rdy, 1'b0);
        tick(); tx_ready = 0;
        @(negedge clk_in); chk("t3_accept", cpu_rdy, 1'b1); chk("t3_head", tx_data, 8'h02);
        tick(); set_cpu(32'h30000, 1, 8'h00);
        @(negedge clk_in); chk("t3_zero_rdy", cpu_rdy, 1'b1);
        tick(); set_idle(); tx_ready = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_in);
            chk("t3_drain", tx_data, (i < 15) ? 8'(i + 2) : 8'h77);
            tick();
        end
        tx_ready = 0;
        @(negedge clk_in); chk("t3_empty", tx_valid, 1'b0);

        // Program stop.
        tick(); set_cpu(32'h30004, 1, 8'h00);
        @(negedge clk_in); chk("t5_pre", stop, 1'b0);
        tick(); set_idle();
        @(negedge clk_in);
        chk("t5_stop", stop, 1'b1); chk("t5_txv", tx_valid, 1'b1); chk("t5_txd", tx_data, 8'h00);
        repeat (5) tick();
        @(negedge clk_in); chk("t5_sticky", stop, 1'b1);
        tick(); tx_ready = 1; tick(); tx_ready = 0;

        // Reset one cycle after an accepted RAM read, with an rx byte queued.
        rx_valid = 1; rx_data = 8'h99;
        set_cpu(32'h10, 0, 8'h00); tick();
        rx_valid = 0; set_idle(); rst_in = 1;
        tick();
        @(negedge clk_in);
        chk("t6_din", cpu_din, 8'h00); chk("t6_txv", tx_valid, 1'b0); chk("t6_stop", stop, 1'b0);
        tick(); rst_in = 0; set_cpu(32'h30000, 0, 0);
        @(negedge clk_in); chk("t6_rx_lost", cpu_rdy, 1'b0);
        tick(); set_cpu(32'h30004, 0, 0);
        tick(); set_idle(); tick();
        @(negedge clk_in); chk("t6_cnt", cpu_din, 8'h01);

        // Write to an unmapped address.
        tick(); set_cpu(32'h20000, 1, 8'h5A);
        @(negedge clk_in); chk("t6_no_we", ram_we, 1'b0);
        tick(); set_idle();
`ifdef MEMIO_BOUNDS_CHECK_EN
        @(negedge clk_in); chk("t6_bad", bad_addr, 1'b1);
`else
        @(negedge clk_in); chk("t6_bad", bad_addr, 1'b0);
`endif
        tick(); tick();
        @(negedge clk_in); chk("t6_ram0", cpu_din, 8'h00);
        tick();

        // Randomized traffic against the model.
        rand_io = 1;
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 35) begin
                a = ($urandom_range(0, 3) == 0) ? 32'h1FFF0 + $urandom_range(0, 15) : $urandom_range(0, 31);
                a[31:24] = 8'($urandom);
                access(a, 1'($urandom), 8'($urandom));
            end else if (r < 55) begin
                access(32'h30000, 1'($urandom), ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom));
            end else if (r < 70) begin
                access(32'h30004 + $urandom_range(0, 3), 0, 8'h00);
            end else if (r < 73) begin
                access(32'h30004, 1, 8'($urandom));
            end else if (r < 85) begin
                case ($urandom_range(0, 2))
                    0:       a = 32'h20000 + $urandom_range(0, 32'hFFFF);
                    1:       a = 32'h30001 + $urandom_range(0, 2);
                    default: a = 32'h30008 + $urandom_range(0, 32'hFFF7);
                endcase
                access(a, 1'($urandom), 8'($urandom));
            end else begin
                access(32'h0, 0, 8'h00);
            end
        end
        rand_io = 0; rx_valid = 0; tx_ready = 0;
        set_idle();
        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
